// File: rtl/lane_training_ctrl_if.sv
// Lane timer handshake: the controller drives timer enables and consumes the
// timer expiry flags.
interface lane_training_ctrl_if;
    logic tdisconnect_tx_min;
    logic tdisconnect_rx_min;
    logic tconnect_rx_min;
    logic tdisabled_min;
    logic ttraining_error_timeout;
    logic tgen4_ts1_timeout;
    logic tgen4_ts2_timeout;
    logic disconnected_s;
    logic fsm_disabled;
    logic fsm_training;
    logic ts1_gen4_s;
    logic ts2_gen4_s;

    // Training controller side.
    modport master (
        input  tdisconnect_tx_min, tdisconnect_rx_min, tconnect_rx_min,
               tdisabled_min, ttraining_error_timeout,
               tgen4_ts1_timeout, tgen4_ts2_timeout,
        output disconnected_s, fsm_disabled, fsm_training,
               ts1_gen4_s, ts2_gen4_s
    );

    // Lane timer block side.
    modport slave (
        output tdisconnect_tx_min, tdisconnect_rx_min, tconnect_rx_min,
               tdisabled_min, ttraining_error_timeout,
               tgen4_ts1_timeout, tgen4_ts2_timeout,
        input  disconnected_s, fsm_disabled, fsm_training,
               ts1_gen4_s, ts2_gen4_s
    );
endinterface

// File: rtl/lane_training_ctrl.sv
// USB4 logical-layer lane bring-up sequencer: DISCONNECTED -> TS1 -> TS2 -> CL0,
// with retry limit and DISABLED. Define FAIL_CNT_EN to add the fail_cnt output.
module lane_training_ctrl #(
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TS1_CNT_REQ = 2,
    parameter int unsigned TS2_CNT_REQ = 2
) (
    input  logic                 clk_b,
    input  logic                 rst,
    lane_training_ctrl_if.master tmr,
    input  logic                 disable_req,
    input  logic                 ts1_rcv,
    input  logic                 ts2_rcv,
    output logic                 cl0_s,
    output logic [2:0]           state,
    output logic [3:0]           retry_cnt,
    output logic                 training_fail
`ifdef FAIL_CNT_EN
    ,
    output logic [7:0]           fail_cnt
`endif
);

    typedef enum logic [2:0] {
        S_DISCONNECTED = 3'd0,
        S_DISABLED     = 3'd1,
        S_TRAIN_TS1    = 3'd2,
        S_TRAIN_TS2    = 3'd3,
        S_CL0          = 3'd4
    } state_e;

    localparam logic [4:0] TS1_REQ     = 5'(TS1_CNT_REQ);
    localparam logic [4:0] TS2_REQ     = 5'(TS2_CNT_REQ);
    localparam logic [4:0] RETRY_LIMIT = 5'(MAX_RETRY);
    localparam logic [3:0] RETRY_SAT   = 4'(MAX_RETRY);

    state_e     state_q, state_d;
    logic [3:0] retry_q, retry_d;
    logic [4:0] ts1_cnt_q, ts1_cnt_d;
    logic [4:0] ts2_cnt_q, ts2_cnt_d;
    logic       fail_pulse_q, fail_pulse_d;
    logic       fail_evt;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; all state, including the ts counters, clears on reset.
    always_ff @(posedge clk_b or negedge rst) begin
        if (!rst) begin
            state_q      <= S_DISCONNECTED;
            retry_q      <= '0;
            ts1_cnt_q    <= '0;
            ts2_cnt_q    <= '0;
            fail_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            ts1_cnt_q    <= ts1_cnt_d;
            ts2_cnt_q    <= ts2_cnt_d;
            fail_pulse_q <= fail_pulse_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        ts1_cnt_d    = '0;
        ts2_cnt_d    = '0;
        fail_pulse_d = 1'b0;
        fail_evt     = 1'b0;

        unique case (state_q)
            S_DISCONNECTED: begin
                if (disable_req)
                    state_d = S_DISABLED;
                else if (tmr.tdisconnect_tx_min && tmr.tconnect_rx_min)
                    state_d = S_TRAIN_TS1;
            end
            S_TRAIN_TS1: begin
                if (disable_req)
                    state_d = S_DISABLED;
                else if (tmr.tdisconnect_rx_min)
                    state_d = S_DISCONNECTED;
                else if (tmr.ttraining_error_timeout || tmr.tgen4_ts1_timeout)
                    fail_evt = 1'b1;
                else if (ts1_rcv && ts1_cnt_q == TS1_REQ - 5'd1)
                    state_d = S_TRAIN_TS2;
                else if (ts1_rcv)
                    ts1_cnt_d = (ts1_cnt_q < TS1_REQ) ? ts1_cnt_q + 5'd1 : ts1_cnt_q;
                else
                    ts1_cnt_d = ts1_cnt_q;
            end
            S_TRAIN_TS2: begin
                if (disable_req)
                    state_d = S_DISABLED;
                else if (tmr.tdisconnect_rx_min)
                    state_d = S_DISCONNECTED;
                else if (tmr.ttraining_error_timeout || tmr.tgen4_ts2_timeout)
                    fail_evt = 1'b1;
                else if (ts2_rcv && ts2_cnt_q == TS2_REQ - 5'd1)
                    state_d = S_CL0;
                else if (ts2_rcv)
                    ts2_cnt_d = (ts2_cnt_q < TS2_REQ) ? ts2_cnt_q + 5'd1 : ts2_cnt_q;
                else
                    ts2_cnt_d = ts2_cnt_q;
            end
            S_CL0: begin
                if (disable_req)
                    state_d = S_DISABLED;
                else if (tmr.tdisconnect_rx_min)
                    state_d = S_DISCONNECTED;
            end
            S_DISABLED: begin
                if (!disable_req && tmr.tdisabled_min) begin
                    state_d = S_DISCONNECTED;
                    retry_d = '0;
                end
            end
            default: state_d = S_DISCONNECTED;
        endcase

        // A failed attempt either charges a retry or, at the limit, parks the lane.
        if (fail_evt) begin
            if ({1'b0, retry_q} + 5'd1 >= RETRY_LIMIT) begin
                state_d      = S_DISABLED;
                retry_d      = RETRY_SAT;
                fail_pulse_d = 1'b1;
            end else begin
                state_d = S_DISCONNECTED;
                retry_d = retry_q + 4'd1;
            end
        end

        if (state_d == S_CL0 && state_q != S_CL0)
            retry_d = '0;
    end

    always_comb begin
        tmr.disconnected_s = (state_q == S_DISCONNECTED);
        tmr.fsm_disabled   = (state_q == S_DISABLED);
        tmr.ts1_gen4_s     = (state_q == S_TRAIN_TS1);
        tmr.ts2_gen4_s     = (state_q == S_TRAIN_TS2);
        tmr.fsm_training   = (state_q == S_TRAIN_TS1) || (state_q == S_TRAIN_TS2);
        cl0_s              = (state_q == S_CL0);
        state              = state_q;
        retry_cnt          = retry_q;
        training_fail      = fail_pulse_q;
    end

`ifdef FAIL_CNT_EN
    logic [7:0] fail_cnt_q;

    always_ff @(posedge clk_b or negedge rst) begin
        if (!rst)
            fail_cnt_q <= '0;
        else if (fail_evt && fail_cnt_q != 8'hFF)
            fail_cnt_q <= fail_cnt_q + 8'd1;
    end

    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_lane_training_ctrl.sv
// Table-driven bench for lane_training_ctrl with a scoreboard queue of
// expected per-cycle outputs, plus a hand-written mid-training reset sequence.
module tb_lane_training_ctrl;

    // Input bit masks: disable, tx_min, con_rx, disc_rx, dis_min, terr, t1to, t2to, ts1, ts2
    localparam logic [9:0] I_NONE = 10'h000;
    localparam logic [9:0] I_DIS  = 10'h200;
    localparam logic [9:0] I_TX   = 10'h100;
    localparam logic [9:0] I_CON  = 10'h080;
    localparam logic [9:0] I_LOST = 10'h040;
    localparam logic [9:0] I_DMIN = 10'h020;
    localparam logic [9:0] I_TERR = 10'h010;
    localparam logic [9:0] I_T1   = 10'h008;
    localparam logic [9:0] I_T2   = 10'h004;
    localparam logic [9:0] I_TS1  = 10'h002;
    localparam logic [9:0] I_TS2  = 10'h001;
    localparam logic [9:0] I_UP   = I_TX | I_CON;

    typedef struct packed {
        logic [9:0] in;
        logic [2:0] st;
        logic [3:0] rt;
        logic       tf;
    } vec_t;

    typedef struct packed {
        logic [7:0] idx;
        logic [2:0] st;
        logic [3:0] rt;
        logic       tf;
    } exp_t;

    logic       clk_b = 1'b0;
    logic       rst   = 1'b0;
    logic       disable_req, ts1_rcv, ts2_rcv;
    logic       cl0_s, training_fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;
`ifdef FAIL_CNT_EN
    logic [7:0] fail_cnt;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;
    vec_t tbl[$];
    exp_t sb[$];

    lane_training_ctrl_if tif ();

    lane_training_ctrl #(.MAX_RETRY(3), .TS1_CNT_REQ(2), .TS2_CNT_REQ(2)) dut (
        .clk_b        (clk_b),
        .rst          (rst),
        .tmr          (tif),
        .disable_req  (disable_req),
        .ts1_rcv      (ts1_rcv),
        .ts2_rcv      (ts2_rcv),
        .cl0_s        (cl0_s),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .training_fail(training_fail)
`ifdef FAIL_CNT_EN
        ,
        .fail_cnt     (fail_cnt)
`endif
    );

    always #5 clk_b = ~clk_b;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] in);
        {disable_req, tif.tdisconnect_tx_min, tif.tconnect_rx_min, tif.tdisconnect_rx_min,
         tif.tdisabled_min, tif.ttraining_error_timeout, tif.tgen4_ts1_timeout,
         tif.tgen4_ts2_timeout, ts1_rcv, ts2_rcv} = in;
    endtask

    // Compare all decoded outputs against one expected state/retry/pulse triple.
    task automatic check_outputs(input int idx, input logic [2:0] st, input logic [3:0] rt, input logic tf);
        logic [4:0] onehot;
        onehot = {st == 3'd0, st == 3'd1, st == 3'd2, st == 3'd3, st == 3'd4};
        check("state", idx, 32'(state), 32'(st));
        check("retry_cnt", idx, 32'(retry_cnt), 32'(rt));
        check("training_fail", idx, 32'(training_fail), 32'(tf));
        check("enables", idx,
              32'({tif.disconnected_s, tif.fsm_disabled, tif.ts1_gen4_s, tif.ts2_gen4_s, cl0_s}),
              32'(onehot));
        check("fsm_training", idx, 32'(tif.fsm_training), 32'(st == 3'd2 || st == 3'd3));
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk_b);
        drive(v.in);
        sb.push_back('{idx: 8'(idx), st: v.st, rt: v.rt, tf: v.tf});
        @(posedge clk_b);
        #1;
        e = sb.pop_front();
        check_outputs(int'(e.idx), e.st, e.rt, e.tf);
    endtask

    function automatic vec_t mk(input logic [9:0] in, input logic [2:0] st, input logic [3:0] rt, input logic tf);
        return '{in: in, st: st, rt: rt, tf: tf};
    endfunction

    initial begin
        // Bring-up to CL0, ts2 ignoring ts1, and CL0 -> DISABLED -> DISCONNECTED.
        tbl.push_back(mk(I_UP,          3'd2, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd2, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd3, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS2,         3'd3, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd3, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS2,         3'd4, 4'd0, 1'b0));
        tbl.push_back(mk(I_NONE,        3'd4, 4'd0, 1'b0));
        tbl.push_back(mk(I_DIS,         3'd1, 4'd0, 1'b0));
        tbl.push_back(mk(I_DIS | I_DMIN, 3'd1, 4'd0, 1'b0));
        tbl.push_back(mk(I_DMIN,        3'd0, 4'd0, 1'b0));
        // Three TS1 timeouts: retry 1, 2, then DISABLED with one-cycle fail pulse.
        tbl.push_back(mk(I_UP,          3'd2, 4'd0, 1'b0));
        tbl.push_back(mk(I_T1,          3'd0, 4'd1, 1'b0));
        tbl.push_back(mk(I_UP,          3'd2, 4'd1, 1'b0));
        tbl.push_back(mk(I_T1,          3'd0, 4'd2, 1'b0));
        tbl.push_back(mk(I_UP,          3'd2, 4'd2, 1'b0));
        tbl.push_back(mk(I_T1,          3'd1, 4'd3, 1'b1));
        tbl.push_back(mk(I_NONE,        3'd1, 4'd3, 1'b0));
        tbl.push_back(mk(I_DMIN,        3'd0, 4'd0, 1'b0));
        // Final ts2 together with timeout: timeout wins.
        tbl.push_back(mk(I_UP,          3'd2, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd2, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd3, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS2,         3'd3, 4'd0, 1'b0));
        tbl.push_back(mk(I_TS2 | I_T2,  3'd0, 4'd1, 1'b0));
        // Disconnect beats training timeout; partial entry conditions; stray pulses.
        tbl.push_back(mk(I_UP,          3'd2, 4'd1, 1'b0));
        tbl.push_back(mk(I_LOST | I_TERR, 3'd0, 4'd1, 1'b0));
        tbl.push_back(mk(I_TX | I_TS1,  3'd0, 4'd1, 1'b0));
        tbl.push_back(mk(I_CON | I_TS2, 3'd0, 4'd1, 1'b0));
        // ts1 count cleared on exit; CL0 entry clears retry.
        tbl.push_back(mk(I_UP,          3'd2, 4'd1, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd2, 4'd1, 1'b0));
        tbl.push_back(mk(I_LOST,        3'd0, 4'd1, 1'b0));
        tbl.push_back(mk(I_UP,          3'd2, 4'd1, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd2, 4'd1, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd3, 4'd1, 1'b0));
        tbl.push_back(mk(I_TS2,         3'd3, 4'd1, 1'b0));
        tbl.push_back(mk(I_TS2,         3'd4, 4'd0, 1'b0));
        tbl.push_back(mk(I_LOST,        3'd0, 4'd0, 1'b0));
        // Training error timeout, then park in TRAIN_TS2 with retry_cnt=1.
        tbl.push_back(mk(I_UP,          3'd2, 4'd0, 1'b0));
        tbl.push_back(mk(I_TERR,        3'd0, 4'd1, 1'b0));
        tbl.push_back(mk(I_UP,          3'd2, 4'd1, 1'b0));
        tbl.push_back(mk(I_TS1 | I_TS2, 3'd2, 4'd1, 1'b0));
        tbl.push_back(mk(I_TS1,         3'd3, 4'd1, 1'b0));

        drive(I_NONE);
        repeat (2) @(posedge clk_b);
        #1;
        check_outputs(-1, 3'd0, 4'd0, 1'b0);
        @(negedge clk_b);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

`ifdef FAIL_CNT_EN
        check("fail_cnt", 100, 32'(fail_cnt), 32'd5);
`endif

        // Reset mid-TRAIN_TS2 with a timeout and ts2 pulse pending.
        #2;
        drive(I_T2 | I_TS2 | I_TERR);
        rst = 1'b0;
        #1;
        check_outputs(200, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_b);
            #1;
            check_outputs(201 + i, 3'd0, 4'd0, 1'b0);
        end
`ifdef FAIL_CNT_EN
        check("fail_cnt", 204, 32'(fail_cnt), 32'd0);
`endif
        @(negedge clk_b);
        drive(I_NONE);
        rst = 1'b1;

        // After reset: disable_req outranks disconnect and timeout in TRAIN_TS1.
        apply(mk(I_NONE,                 3'd0, 4'd0, 1'b0), 300);
        apply(mk(I_UP,                   3'd2, 4'd0, 1'b0), 301);
        apply(mk(I_DIS | I_LOST | I_T1,  3'd1, 4'd0, 1'b0), 302);
        apply(mk(I_DMIN,                 3'd0, 4'd0, 1'b0), 303);

        check("sb_empty", 400, 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
